// File: rtl/id_reorder_buffer_pkg.sv
// Shared types for the ID reorder buffer.
// Slot structs depend on module parameters, so only the state enum lives here.
package id_reorder_buffer_pkg;

    typedef enum logic [1:0] {
        FREE    = 2'd0,
        PENDING = 2'd1,
        FILLED  = 2'd2
    } slot_state_e;

endpackage

// File: rtl/id_reorder_buffer_sva.sv
// Assertion checker for id_reorder_buffer: occupancy bound, output stability and
// parameter legality.
module id_reorder_buffer_sva #(
    parameter int unsigned ID_WIDTH = 1,
    parameter int unsigned CAPACITY = 4,
    parameter int unsigned data_w   = 1,
    parameter int unsigned CNT_W    = 3
) (
    input logic                clk_i,
    input logic                rst_ni,
    input logic [CNT_W-1:0]    count,
    input logic                oup_valid,
    input logic                oup_ready,
    input logic [ID_WIDTH-1:0] oup_id,
    input logic [data_w-1:0]   oup_data
);

    if (CAPACITY < 2) begin : g_bad_capacity
        $fatal(1, "id_reorder_buffer: CAPACITY must be >= 2");
    end
    if (ID_WIDTH < 1 || data_w < 1) begin : g_bad_width
        $fatal(1, "id_reorder_buffer: ID_WIDTH and data_w must be >= 1");
    end

    a_count_bound : assert property (@(posedge clk_i) disable iff (!rst_ni)
        count <= CNT_W'(CAPACITY))
        else $error("id_reorder_buffer: count exceeds CAPACITY");

    a_valid_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (oup_valid && !oup_ready) |=> (oup_valid && $stable(oup_id) && $stable(oup_data)))
        else $error("id_reorder_buffer: output changed before handshake");

endmodule

// File: rtl/lzc.sv
// Common leading/trailing zero counter.
// MODE 0 counts trailing zeros (index of the lowest set bit); MODE 1 counts leading zeros.
module lzc #(
    parameter int unsigned WIDTH     = 2,
    parameter bit          MODE      = 1'b0,
    parameter int unsigned CNT_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0]     in_i,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 empty_o
);

    // Priority scan; the last hit in scan order is the winning position.
    always_comb begin
        cnt_o   = '0;
        empty_o = 1'b1;
        for (int unsigned k = 0; k < WIDTH; k++) begin
            if (MODE == 1'b0) begin
                cnt_o   = in_i[WIDTH-1-k] ? CNT_WIDTH'(WIDTH - 1 - k) : cnt_o;
                empty_o = in_i[WIDTH-1-k] ? 1'b0 : empty_o;
            end else begin
                cnt_o   = in_i[k] ? CNT_WIDTH'(WIDTH - 1 - k) : cnt_o;
                empty_o = in_i[k] ? 1'b0 : empty_o;
            end
        end
    end

endmodule

// File: rtl/id_reorder_buffer.sv
// Restores global issue order for ID-tagged responses that are ordered per ID only.
// Requests claim slots in a circular table; responses fill the oldest pending slot of their ID.
module id_reorder_buffer
    import id_reorder_buffer_pkg::*;
#(
    parameter int unsigned ID_WIDTH = 1,
    parameter int unsigned CAPACITY = 4,
    parameter int unsigned data_w   = 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [ID_WIDTH-1:0] alloc_id_i,
    input  logic                alloc_req_i,
    output logic                alloc_gnt_o,
    input  logic [ID_WIDTH-1:0] rsp_id_i,
    input  logic [data_w-1:0]   rsp_data_i,
    input  logic                rsp_valid_i,
    output logic [ID_WIDTH-1:0] oup_id_o,
    output logic [data_w-1:0]   oup_data_o,
    output logic                oup_valid_o,
    input  logic                oup_ready_i,
    output logic                err_o,
    output logic                empty_o
);

    localparam int unsigned PTR_W = $clog2(CAPACITY);
    localparam int unsigned SUM_W = PTR_W + 1;
    localparam int unsigned CNT_W = $clog2(CAPACITY + 1);

    typedef struct packed {
        logic [ID_WIDTH-1:0] id;
        logic [data_w-1:0]   data;
        slot_state_e         state;
    } slot_t;

    slot_t              slots_r [CAPACITY];
    logic [PTR_W-1:0]   head_r;
    logic [PTR_W-1:0]   tail_r;
    logic [CNT_W-1:0]   count_r;
    logic               err_r;

    logic [CAPACITY-1:0] cand_s;
    logic [CAPACITY-1:0] rot_s;
    logic [PTR_W-1:0]    lzc_cnt_s;
    logic                lzc_empty_s;
    logic [SUM_W-1:0]    hit_sum_s;
    logic [PTR_W-1:0]    hit_idx_s;
    logic                hit_s;
    logic                do_alloc_s;
    logic                do_pop_s;
    logic                do_fill_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(CAPACITY - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Slots eligible to take the current response.
    always_comb begin
        cand_s = '0;
        for (int unsigned i = 0; i < CAPACITY; i++) begin
            cand_s[i] = (slots_r[i].state == PENDING) && (slots_r[i].id == rsp_id_i);
        end
    end

    // Rotate candidates so bit 0 is the head slot; lowest set bit is then the oldest.
    always_comb begin
        logic [SUM_W-1:0] src;
        src   = '0;
        rot_s = '0;
        for (int unsigned j = 0; j < CAPACITY; j++) begin
            src      = SUM_W'(j) + {1'b0, head_r};
            src      = (src >= SUM_W'(CAPACITY)) ? src - SUM_W'(CAPACITY) : src;
            rot_s[j] = cand_s[src[PTR_W-1:0]];
        end
    end

    lzc #(
        .WIDTH     (CAPACITY),
        .MODE      (1'b0),
        .CNT_WIDTH (PTR_W)
    ) u_oldest_match (
        .in_i    (rot_s),
        .cnt_o   (lzc_cnt_s),
        .empty_o (lzc_empty_s)
    );

    // Un-rotate the winning offset back to a table index.
    always_comb begin
        hit_sum_s = {1'b0, head_r} + {1'b0, lzc_cnt_s};
        hit_sum_s = (hit_sum_s >= SUM_W'(CAPACITY)) ? hit_sum_s - SUM_W'(CAPACITY) : hit_sum_s;
        hit_idx_s = hit_sum_s[PTR_W-1:0];
        hit_s     = !lzc_empty_s;
    end

    assign alloc_gnt_o = (count_r < CNT_W'(CAPACITY));
    assign do_alloc_s  = alloc_req_i && alloc_gnt_o;
    assign do_pop_s    = oup_valid_o && oup_ready_i;
    assign do_fill_s   = rsp_valid_i && hit_s;

    // Table, pointer and error-flag state; alloc, fill and pop always hit distinct slots.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < CAPACITY; i++) begin
                slots_r[i] <= '0;
            end
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
            err_r   <= 1'b0;
        end else begin
            err_r <= rsp_valid_i && !hit_s;
            if (do_alloc_s) begin
                slots_r[tail_r].id    <= alloc_id_i;
                slots_r[tail_r].data  <= '0;
                slots_r[tail_r].state <= PENDING;
                tail_r                <= ptr_inc(tail_r);
            end
            if (do_fill_s) begin
                slots_r[hit_idx_s].data  <= rsp_data_i;
                slots_r[hit_idx_s].state <= FILLED;
            end
            if (do_pop_s) begin
                slots_r[head_r].state <= FREE;
                head_r                <= ptr_inc(head_r);
            end
            count_r <= count_r + CNT_W'(do_alloc_s) - CNT_W'(do_pop_s);
        end
    end

    assign oup_valid_o = (slots_r[head_r].state == FILLED);
    assign oup_id_o    = slots_r[head_r].id;
    assign oup_data_o  = slots_r[head_r].data;
    assign err_o       = err_r;
    assign empty_o     = (count_r == CNT_W'(0));

    id_reorder_buffer_sva #(
        .ID_WIDTH (ID_WIDTH),
        .CAPACITY (CAPACITY),
        .data_w   (data_w),
        .CNT_W    (CNT_W)
    ) u_sva (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .count     (count_r),
        .oup_valid (oup_valid_o),
        .oup_ready (oup_ready_i),
        .oup_id    (oup_id_o),
        .oup_data  (oup_data_o)
    );

endmodule

// File: tb/tb_id_reorder_buffer.sv
// Scoreboard bench for id_reorder_buffer: a queue of outstanding requests in issue order is
// the reference; a negedge monitor pops and compares on every output handshake.
module tb_id_reorder_buffer;

    localparam int ID_W = 2;
    localparam int CAP  = 4;
    localparam int DW   = 8;

    typedef struct {
        logic [ID_W-1:0] id;
        logic [DW-1:0]   data;
        bit              filled;
    } ent_t;

    logic            clk = 1'b0;
    logic            rst_ni;
    logic [ID_W-1:0] alloc_id_i;
    logic            alloc_req_i;
    logic            alloc_gnt_o;
    logic [ID_W-1:0] rsp_id_i;
    logic [DW-1:0]   rsp_data_i;
    logic            rsp_valid_i;
    logic [ID_W-1:0] oup_id_o;
    logic [DW-1:0]   oup_data_o;
    logic            oup_valid_o;
    logic            oup_ready_i;
    logic            err_o;
    logic            empty_o;

    ent_t                model[$];
    logic [ID_W+DW-1:0]  pop_log[$];
    bit                  pending_err = 1'b0;
    bit                  exp_err = 1'b0;
    int                  checks = 0;
    int                  errors = 0;

    id_reorder_buffer #(.ID_WIDTH(ID_W), .CAPACITY(CAP), .data_w(DW)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .alloc_id_i  (alloc_id_i),
        .alloc_req_i (alloc_req_i),
        .alloc_gnt_o (alloc_gnt_o),
        .rsp_id_i    (rsp_id_i),
        .rsp_data_i  (rsp_data_i),
        .rsp_valid_i (rsp_valid_i),
        .oup_id_o    (oup_id_o),
        .oup_data_o  (oup_data_o),
        .oup_valid_o (oup_valid_o),
        .oup_ready_i (oup_ready_i),
        .err_o       (err_o),
        .empty_o     (empty_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // err_o is registered: the expectation formed while driving becomes due after the edge.
    always @(posedge clk) exp_err <= rst_ni ? pending_err : 1'b0;

    // Monitor: compare error flag and every handshaken output against the reference queue.
    always @(negedge clk) begin
        if (rst_ni) begin
            checks++;
            if (err_o !== exp_err) begin
                errors++;
                $display("FAIL err_o actual=%0b required=%0b at %0t", err_o, exp_err, $time);
            end
            if (oup_valid_o) begin
                checks++;
                if (model.size() == 0 || !model[0].filled) begin
                    errors++;
                    $display("FAIL out_unexpected actual=valid(%0h,%0h) required=no output at %0t",
                             oup_id_o, oup_data_o, $time);
                end else if (oup_ready_i) begin
                    if (oup_id_o !== model[0].id || oup_data_o !== model[0].data) begin
                        errors++;
                        $display("FAIL out_order actual=(%0h,%0h) required=(%0h,%0h) at %0t",
                                 oup_id_o, oup_data_o, model[0].id, model[0].data, $time);
                    end
                    pop_log.push_back({oup_id_o, oup_data_o});
                    void'(model.pop_front());
                end
            end
        end
    end

    // One cycle of stimulus; the reference applies the response before the alloc so a
    // same-cycle alloc cannot absorb it.
    task automatic step(input bit a, input logic [ID_W-1:0] aid, input bit r,
                        input logic [ID_W-1:0] rid, input logic [DW-1:0] rd, input bit rdy);
        bit hit;
        chk("alloc_gnt", 32'(alloc_gnt_o), 32'(model.size() < CAP));
        chk("empty", 32'(empty_o), 32'(model.size() == 0));
        alloc_req_i = a;
        alloc_id_i  = aid;
        rsp_valid_i = r;
        rsp_id_i    = rid;
        rsp_data_i  = rd;
        oup_ready_i = rdy;
        pending_err = 1'b0;
        if (r) begin
            hit = 1'b0;
            foreach (model[i]) begin
                if (!hit && !model[i].filled && model[i].id == rid) begin
                    model[i].data   = rd;
                    model[i].filled = 1'b1;
                    hit = 1'b1;
                end
            end
            pending_err = !hit;
        end
        if (a && model.size() < CAP) model.push_back('{aid, '0, 1'b0});
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (model.size() != 0 && n < 30) begin
            step(1'b0, '0, 1'b0, '0, '0, 1'b1);
            n++;
        end
        chk("drain_timeout", 32'(model.size()), 32'd0);
        step(1'b0, '0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic answer_all();
        int guard;
        guard = 0;
        while (guard < 10) begin
            int idx;
            idx = -1;
            foreach (model[i]) if (idx < 0 && !model[i].filled) idx = i;
            if (idx < 0) break;
            step(1'b0, '0, 1'b1, model[idx].id, 8'($urandom), 1'b0);
            guard++;
        end
    endtask

    initial begin
        logic [ID_W+DW-1:0] exp_seq [3];
        rst_ni = 1'b0; alloc_req_i = 1'b0; alloc_id_i = '0; rsp_valid_i = 1'b0;
        rsp_id_i = '0; rsp_data_i = '0; oup_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_gnt", 32'(alloc_gnt_o), 32'd1);
        chk("reset_empty", 32'(empty_o), 32'd1);
        chk("reset_valid", 32'(oup_valid_o), 32'd0);
        chk("reset_err", 32'(err_o), 32'd0);
        chk("reset_id", 32'(oup_id_o), 32'd0);
        chk("reset_data", 32'(oup_data_o), 32'd0);
        rst_ni = 1'b1;
        step(1'b0, '0, 1'b0, '0, '0, 1'b0);

        // Cross-ID reordering.
        pop_log.delete();
        step(1'b1, 2'd0, 1'b0, '0, '0, 1'b0);
        step(1'b1, 2'd1, 1'b0, '0, '0, 1'b0);
        step(1'b1, 2'd0, 1'b0, '0, '0, 1'b0);
        step(1'b0, '0, 1'b1, 2'd1, 8'h0B, 1'b0);
        step(1'b0, '0, 1'b1, 2'd0, 8'h0A, 1'b0);
        step(1'b0, '0, 1'b1, 2'd0, 8'h0C, 1'b0);
        drain();
        exp_seq[0] = {2'd0, 8'h0A};
        exp_seq[1] = {2'd1, 8'h0B};
        exp_seq[2] = {2'd0, 8'h0C};
        chk("order_len", 32'(pop_log.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            chk("order_seq", (i < pop_log.size()) ? 32'(pop_log[i]) : 32'hFFFF_FFFF, 32'(exp_seq[i]));
        end

        // Full table: pop and alloc together -> alloc refused, granted next cycle.
        for (int i = 0; i < CAP; i++) step(1'b1, 2'(i), 1'b0, '0, '0, 1'b0);
        chk("full_gnt", 32'(alloc_gnt_o), 32'd0);
        step(1'b0, '0, 1'b1, 2'd0, 8'h55, 1'b0);
        step(1'b1, 2'd3, 1'b0, '0, '0, 1'b1);
        chk("after_pop_gnt", 32'(alloc_gnt_o), 32'd1);
        step(1'b1, 2'd2, 1'b0, '0, '0, 1'b0);
        chk("regrant_empty", 32'(empty_o), 32'd0);
        answer_all();
        drain();

        // Response with no pending slot of that ID.
        step(1'b1, 2'd0, 1'b0, '0, '0, 1'b0);
        step(1'b0, '0, 1'b1, 2'd3, 8'hEE, 1'b1);
        step(1'b0, '0, 1'b0, '0, '0, 1'b1);
        chk("miss_valid", 32'(oup_valid_o), 32'd0);
        answer_all();
        drain();

        // Randomized traffic with random back-pressure; wraps the pointers many times.
        for (int c = 0; c < 120; c++) begin
            bit a, r;
            logic [ID_W-1:0] rid;
            int pend[$];
            pend.delete();
            foreach (model[i]) if (!model[i].filled) pend.push_back(i);
            a   = ($urandom_range(0, 1) == 1);
            r   = ($urandom_range(0, 2) != 0);
            rid = 2'($urandom);
            if (pend.size() != 0 && $urandom_range(0, 7) != 0)
                rid = model[pend[$urandom_range(0, pend.size() - 1)]].id;
            step(a, 2'($urandom), r, rid, 8'($urandom), $urandom_range(0, 1) == 1);
        end
        answer_all();
        drain();

        // Reset mid-operation with pending and filled slots.
        step(1'b1, 2'd0, 1'b0, '0, '0, 1'b0);
        step(1'b1, 2'd1, 1'b0, '0, '0, 1'b0);
        step(1'b1, 2'd2, 1'b0, '0, '0, 1'b0);
        step(1'b0, '0, 1'b1, 2'd0, 8'h77, 1'b0);
        chk("pre_reset_valid", 32'(oup_valid_o), 32'd1);
        rst_ni = 1'b0;
        alloc_req_i = 1'b0; rsp_valid_i = 1'b0; oup_ready_i = 1'b0;
        model.delete();
        pending_err = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_reset_empty", 32'(empty_o), 32'd1);
        chk("mid_reset_valid", 32'(oup_valid_o), 32'd0);
        chk("mid_reset_err", 32'(err_o), 32'd0);
        rst_ni = 1'b1;
        step(1'b0, '0, 1'b1, 2'd1, 8'h99, 1'b0);
        chk("late_rsp_err", 32'(err_o), 32'd1);
        step(1'b0, '0, 1'b0, '0, '0, 1'b0);
        chk("late_rsp_err_clear", 32'(err_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
